// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 blocks of 4 bytes.
// Hits complete without stalling; misses evict a dirty victim, then refill.
module data_cache (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned BLOCK_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2
  } state_t;

  state_t                   r_state;
  logic [BLOCK_W-1:0]       r_data [NUM_BLOCKS];
  logic [TAG_W-1:0]         r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]    r_valid;
  logic [NUM_BLOCKS-1:0]    r_dirty;
  logic [TAG_W-1:0]         r_miss_tag;
  logic [IDX_W-1:0]         r_miss_idx;

  logic [TAG_W-1:0]         w_tag;
  logic [IDX_W-1:0]         w_index;
  logic [OFF_W-1:0]         w_offset;
  logic [BLOCK_W-1:0]       w_block;
  logic                     w_req;
  logic                     w_hit;
  logic                     w_fill;

  assign w_tag    = address[7:5];
  assign w_index  = address[4:2];
  assign w_offset = address[1:0];
  assign w_block  = r_data[w_index];
  assign w_req    = read | write;
  assign w_hit    = (r_state == S_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill   = (r_state == S_FETCH) && !mem_busywait;

  // Stall is gated by reset so an aborted miss releases the CPU at once.
  assign busywait = reset & w_req & ~w_hit;
  assign readdata = 8'(w_block >> {w_offset, 3'b000});

  // Controller: miss sequencing, tag-state bits and memory request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_miss_tag    <= '0;
      r_miss_idx    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_index;
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state       <= S_WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {r_tag[w_index], w_index};
              mem_writedata <= r_data[w_index];
            end else begin
              r_state     <= S_FETCH;
              mem_read    <= 1'b1;
              mem_address <= {w_tag, w_index};
            end
          end else if (write && w_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (!mem_busywait) begin
            r_state     <= S_FETCH;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {r_miss_tag, r_miss_idx};
          end
        end
        S_FETCH: begin
          if (!mem_busywait) begin
            r_state             <= S_IDLE;
            mem_read            <= 1'b0;
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Block payload and tags carry no reset; valid bits make them meaningful.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_miss_idx] <= mem_readdata;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end else if (write && w_hit) begin
      r_data[w_index][{w_offset, 3'b000} +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a behavioural cache/memory model predicts
// read data and memory traffic; monitors compare whenever the DUT presents them.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  data_cache dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memory bus model ----------------
  logic [31:0] seed_mem [64];
  logic [31:0] phys_mem [64];
  bit          mem_filled = 1'b0;
  int          lat = 0;
  int          cnt = 0;
  bit          force_busy = 1'b0;

  assign mem_busywait = force_busy | ((mem_read | mem_write) && (cnt < lat));
  assign mem_readdata = phys_mem[mem_address];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 0;
      if (!mem_filled) begin
        for (int k = 0; k < 64; k++) phys_mem[k] <= seed_mem[k];
        mem_filled <= 1'b1;
      end
    end else if ((mem_read | mem_write) && !mem_busywait) begin
      cnt <= 0;
      if (mem_write) phys_mem[mem_address] <= mem_writedata;
    end else if (mem_read | mem_write) begin
      cnt <= cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mop_t;

  mop_t        mq[$];
  logic [7:0]  rq[$];
  logic [31:0] rmem [64];
  logic [31:0] rdat [8];
  logic [2:0]  rtag [8];
  bit          rv [8];
  bit          rd [8];

  function automatic bit ref_hit(input logic [7:0] a);
    logic [2:0] i;
    i = a[4:2];
    return rv[i] && (rtag[i] == a[7:5]);
  endfunction

  task automatic ref_access(input logic [7:0] a, input bit wr, input logic [7:0] wd);
    logic [2:0] t, i;
    logic [1:0] o;
    mop_t m;
    t = a[7:5]; i = a[4:2]; o = a[1:0];
    if (!ref_hit(a)) begin
      if (rv[i] && rd[i]) begin
        m.wr = 1'b1; m.addr = {rtag[i], i}; m.data = rdat[i];
        mq.push_back(m);
        rmem[{rtag[i], i}] = rdat[i];
      end
      m.wr = 1'b0; m.addr = {t, i}; m.data = '0;
      mq.push_back(m);
      rdat[i] = rmem[{t, i}];
      rtag[i] = t; rv[i] = 1'b1; rd[i] = 1'b0;
    end
    if (wr) begin
      rdat[i][{o, 3'b000} +: 8] = wd;
      rd[i] = 1'b1;
    end else begin
      rq.push_back(rdat[i][{o, 3'b000} +: 8]);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset && read && !write && !busywait) begin
      if (rq.size() == 0) chk("unexpected_read_done", 32'(readdata), 32'hxxxx_xxxx);
      else chk("readdata", 32'(readdata), 32'(rq.pop_front()));
    end
  end

  always @(negedge clk) begin
    mop_t e;
    if (reset && (mem_read | mem_write) && !mem_busywait) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_op", {mem_read, mem_write, mem_address}, 32'h0);
      end else begin
        e = mq.pop_front();
        chk("mem_op_is_write", 32'(mem_write), 32'(e.wr));
        chk("mem_op_is_read", 32'(mem_read), 32'(!e.wr));
        chk("mem_address", 32'(mem_address), 32'(e.addr));
        if (e.wr) chk("mem_writedata", mem_writedata, e.data);
        chk("busywait_during_miss", 32'(busywait), 32'd1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic [7:0] a, input bit wr, input bit rd_too,
                        input logic [7:0] wd, input int l);
    bit exp_hit;
    int n;
    exp_hit = ref_hit(a);
    lat = l;
    read = wr ? rd_too : 1'b1;
    write = wr;
    address = a;
    writedata = wd;
    ref_access(a, wr, wd);
    @(negedge clk);
    chk("first_cycle_busywait", 32'(busywait), 32'(!exp_hit));
    n = 0;
    while (busywait && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busywait) chk("stall_timeout", 32'(busywait), 32'd0);
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 64; k++) seed_mem[k] = $urandom;
    seed_mem[9] = 32'hDDCCBBAA;
    for (int k = 0; k < 64; k++) rmem[k] = seed_mem[k];
    for (int k = 0; k < 8; k++) begin rv[k] = 1'b0; rd[k] = 1'b0; rtag[k] = '0; rdat[k] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busywait", 32'(busywait), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_address", 32'(mem_address), 32'd0);
    chk("reset_mem_writedata", mem_writedata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Cold miss, hits on the same block, write hit, then dirty eviction.
    access(8'h25, 1'b0, 1'b0, 8'h00, 5);
    access(8'h27, 1'b0, 1'b0, 8'h00, 0);
    access(8'h24, 1'b1, 1'b0, 8'h5A, 0);
    access(8'h24, 1'b0, 1'b0, 8'h00, 0);
    access(8'h44, 1'b0, 1'b0, 8'h00, 3);
    // Clean eviction of the same index.
    access(8'h26, 1'b0, 1'b0, 8'h00, 2);

    // Idle: memory busy must not provoke a stall or any request.
    force_busy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busywait", 32'(busywait), 32'd0);
      chk("idle_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
    end
    force_busy = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic over a few tags to mix hits, clean and dirty misses.
    for (int k = 0; k < 150; k++) begin
      logic [7:0] a;
      a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), $urandom_range(0, 4));
    end

    // Reset in the middle of a refill.
    lat = 20;
    read = 1'b1;
    address = 8'h80;
    n = 0;
    while (!mem_read && n < 10) begin @(negedge clk); n++; end
    chk("fetch_started", 32'(mem_read), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_busywait", 32'(busywait), 32'd0);
    @(posedge clk); #1;
    read = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin rv[k] = 1'b0; rd[k] = 1'b0; end
    @(posedge clk); #1;

    // After reset every index misses.
    for (int k = 0; k < 8; k++) access({3'd1, 3'(k), 2'd0}, 1'b0, 1'b0, 8'h00, 1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      a = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(a, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
